countdown_timer: RTL

- mm:ss BCD countdown timer. It counts down instead of up, and its digit chain emits borrows where our up-counters emit carries.
- Uses mod-10 and mod-6 down-digits, so the tens-of-seconds digit is the downward mod-6 counterpart of the team's mod-6 up-counter.
- Sits beside the clock counters on the board design, driven from the system clock through an internal prescaler.
- Raises a one-cycle expiry pulse when it reaches 00:00.

---
 rtl/countdown_pkg.sv | 22 ++
 rtl/countdown_timer_down_digit.sv | 43 ++++
 rtl/countdown_timer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/countdown_pkg.sv
// countdown_pkg: shared state encoding, digit widths and digit maxima for the
// mm:ss BCD countdown timer.
package countdown_pkg;

    // Top-level timer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Digit widths: BCD digits are 4 bits, seconds tens only needs 3.
    localparam int DIGIT_W      = 4;
    localparam int SEC_TENS_W   = 3;

    // Largest legal value of each digit kind.
    localparam int ONES_MAX     = 9;
    localparam int SEC_TENS_MAX = 5;
    localparam int MIN_TENS_MAX = 9;

endpackage

// File: rtl/countdown_timer_down_digit.sv
// down_digit: one modulo-(MAX+1) down-counting digit with a synchronous
// clamped load and a combinational borrow output for chaining.
module down_digit #(
    parameter int WIDTH = 4,
    parameter int MAX   = 9
) (
    input  logic             sysClk,
    input  logic             sysRst,
    input  logic             load,
    input  logic [WIDTH-1:0] loadVal,
    input  logic             dec,
    output logic [WIDTH-1:0] q,
    output logic             borrowOut
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next digit value: load (clamped to MAX) beats a decrement; 0 wraps to MAX.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = (loadVal > MAX_V) ? MAX_V : loadVal;
        end else if (dec) begin
            q_d = (q_q == '0) ? MAX_V : (q_q - WIDTH'(1));
        end
    end

    // Digit register with asynchronous clear.
    always_ff @(posedge sysClk or posedge sysRst) begin
        if (sysRst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q         = q_q;
    assign borrowOut = dec & (q_q == '0);

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: mm:ss BCD countdown with an internal one-second prescaler,
// IDLE/RUN/PAUSE/DONE control and a one-cycle expiry pulse at 00:00.
// Optional feature macro COUNTDOWN_AUTORELOAD_EN: keep the last loaded preset
// in a shadow register and restart from it on expiry instead of stopping.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int TICK_DIV = 10,
    parameter int PRE_W    = 16
) (
    input  logic                  sysClk,
    input  logic                  sysRst,
    input  logic                  load,
    input  logic                  start,
    input  logic                  pause,
    input  logic [DIGIT_W-1:0]    presetMinTens,
    input  logic [DIGIT_W-1:0]    presetMinOnes,
    input  logic [SEC_TENS_W-1:0] presetSecTens,
    input  logic [DIGIT_W-1:0]    presetSecOnes,
    output logic [DIGIT_W-1:0]    minTens,
    output logic [DIGIT_W-1:0]    minOnes,
    output logic [SEC_TENS_W-1:0] secTens,
    output logic [DIGIT_W-1:0]    secOnes,
    output logic                  running,
    output logic                  done,
    output logic                  expired
);

    localparam logic [PRE_W-1:0] TICK_LAST = PRE_W'(TICK_DIV - 1);

    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic             expired_q, expired_d;

    logic                  load_accept;
    logic                  dec_en;
    logic                  digit_load;
    logic [DIGIT_W-1:0]    ld_min_tens, ld_min_ones, ld_sec_ones;
    logic [SEC_TENS_W-1:0] ld_sec_tens;
    logic                  so_borrow, st_borrow, mo_borrow, unused_top_borrow;
    logic                  time_zero, time_one, tick;

    assign time_zero = (minTens == '0) && (minOnes == '0) && (secTens == '0) && (secOnes == '0);
    assign time_one  = (minTens == '0) && (minOnes == '0) && (secTens == '0) && (secOnes == DIGIT_W'(1));
    assign tick      = (pre_q == TICK_LAST);

`ifdef COUNTDOWN_AUTORELOAD_EN
    logic                  reload;
    logic [DIGIT_W-1:0]    sh_min_tens_q, sh_min_ones_q, sh_sec_ones_q;
    logic [SEC_TENS_W-1:0] sh_sec_tens_q;

    // Shadow copy of the most recently accepted preset, used to restart on expiry.
    always_ff @(posedge sysClk or posedge sysRst) begin
        if (sysRst) begin
            sh_min_tens_q <= '0;
            sh_min_ones_q <= '0;
            sh_sec_tens_q <= '0;
            sh_sec_ones_q <= '0;
        end else if (load_accept) begin
            sh_min_tens_q <= presetMinTens;
            sh_min_ones_q <= presetMinOnes;
            sh_sec_tens_q <= presetSecTens;
            sh_sec_ones_q <= presetSecOnes;
        end
    end

    assign reload      = dec_en & time_one;
    assign digit_load  = load_accept | reload;
    assign ld_min_tens = reload ? sh_min_tens_q : presetMinTens;
    assign ld_min_ones = reload ? sh_min_ones_q : presetMinOnes;
    assign ld_sec_tens = reload ? sh_sec_tens_q : presetSecTens;
    assign ld_sec_ones = reload ? sh_sec_ones_q : presetSecOnes;
`else
    assign digit_load  = load_accept;
    assign ld_min_tens = presetMinTens;
    assign ld_min_ones = presetMinOnes;
    assign ld_sec_tens = presetSecTens;
    assign ld_sec_ones = presetSecOnes;
`endif

    // Control: next state, prescaler, load acceptance, decrement request and expiry.
    always_comb begin
        state_d     = state_q;
        pre_d       = pre_q;
        expired_d   = 1'b0;
        load_accept = 1'b0;
        dec_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pre_d = '0;
                if (load) begin
                    load_accept = 1'b1;
                end else if (start && !time_zero) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (pause) begin
                    state_d = ST_PAUSE;
                end else if (tick) begin
                    pre_d = '0;
                    if (!time_zero) begin
                        dec_en = 1'b1;
                        if (time_one) begin
                            expired_d = 1'b1;
`ifndef COUNTDOWN_AUTORELOAD_EN
                            state_d   = ST_DONE;
`endif
                        end
                    end
                end else begin
                    pre_d = pre_q + PRE_W'(1);
                end
            end
            ST_PAUSE: begin
                if (load) begin
                    load_accept = 1'b1;
                    state_d     = ST_IDLE;
                    pre_d       = '0;
                end else if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                pre_d = '0;
                if (load) begin
                    load_accept = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pre_d   = '0;
            end
        endcase
        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
    end

    // Control registers, including the registered status outputs.
    always_ff @(posedge sysClk or posedge sysRst) begin
        if (sysRst) begin
            state_q   <= ST_IDLE;
            pre_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            running_q <= running_d;
            done_q    <= done_d;
            expired_q <= expired_d;
        end
    end

    // Borrow chain: seconds ones -> seconds tens -> minutes ones -> minutes tens.
    down_digit #(.WIDTH(DIGIT_W), .MAX(ONES_MAX)) u_sec_ones (
        .sysClk(sysClk), .sysRst(sysRst), .load(digit_load), .loadVal(ld_sec_ones),
        .dec(dec_en), .q(secOnes), .borrowOut(so_borrow)
    );
    down_digit #(.WIDTH(SEC_TENS_W), .MAX(SEC_TENS_MAX)) u_sec_tens (
        .sysClk(sysClk), .sysRst(sysRst), .load(digit_load), .loadVal(ld_sec_tens),
        .dec(so_borrow), .q(secTens), .borrowOut(st_borrow)
    );
    down_digit #(.WIDTH(DIGIT_W), .MAX(ONES_MAX)) u_min_ones (
        .sysClk(sysClk), .sysRst(sysRst), .load(digit_load), .loadVal(ld_min_ones),
        .dec(st_borrow), .q(minOnes), .borrowOut(mo_borrow)
    );
    // Top digit never borrows since 00:00 is never decremented.
    down_digit #(.WIDTH(DIGIT_W), .MAX(MIN_TENS_MAX)) u_min_tens (
        .sysClk(sysClk), .sysRst(sysRst), .load(digit_load), .loadVal(ld_min_tens),
        .dec(mo_borrow), .q(minTens), .borrowOut(unused_top_borrow)
    );

    assign running = running_q;
    assign done    = done_q;
    assign expired = expired_q;

endmodule
